// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit and its ALU control.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_ADDI_EX = 4'd11,
    S_ADDI_WB = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // States that hold the unified memory and stretch until done.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-done generator: fixed MEM_LAT-cycle count cleared by entry_i, or pass-through of mem_ready_i.
// done_o is combinational from the count / mem_ready_i; no internal backpressure.
module mem_wait_timer #(
  parameter int MEM_LAT   = 1,
  parameter int USE_READY = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic entry_i,
  input  logic mem_ready_i,
  output logic done_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = (USE_READY != 0) ? mem_ready_i : (cnt_q == LAST);

  // Free-running outside memory states; only the value after entry matters.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (entry_i) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: controls decoded from registered state, memory states stretched by done.
// Counts retired instructions; start_i is sampled in IDLE and at each instruction boundary.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MEM_LAT   = 1,
  parameter int USE_READY = 0,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       Op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             MemtoReg_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic [1:0]       PCSource_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o,
  output logic [3:0]       state_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             done;
  logic             finish;
  logic             mem_entry;

  assign mem_entry = is_mem_state(state_d) && (state_d != state_q);

  mem_wait_timer #(
    .MEM_LAT  (MEM_LAT),
    .USE_READY(USE_READY)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .entry_i    (mem_entry),
    .mem_ready_i(mem_ready_i),
    .done_o     (done)
  );

  always_comb begin
    state_d       = state_q;
    retired_d     = retired_q;
    finish        = 1'b0;
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = SRCB_REG;
    ALUOp_o       = ALUOP_ADD;
    PCSource_o    = PCSRC_ALU;
    illegal_o     = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_FETCH;
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        if (done) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ALUSrcB_o = SRCB_IMM_SL2;
        case (Op_i)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            illegal_o = 1'b1;
            state_d   = start_i ? S_FETCH : S_IDLE;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = (Op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead_o = 1'b1;
        IorD_o    = 1'b1;
        if (done) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = 1'b1;
        finish     = 1'b1;
      end
      S_MEMWR: begin
        MemWrite_o = 1'b1;
        IorD_o     = 1'b1;
        finish     = done;
      end
      S_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = ALUOP_FUNCT;
        state_d   = S_RWB;
      end
      S_RWB: begin
        RegWrite_o = 1'b1;
        RegDst_o   = 1'b1;
        finish     = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = ALUOP_SUB;
        PCWriteCond_o = 1'b1;
        PCSource_o    = PCSRC_ALUOUT;
        finish        = 1'b1;
      end
      S_JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = PCSRC_JUMP;
        finish     = 1'b1;
      end
      S_ADDI_EX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite_o = 1'b1;
        finish     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (finish) begin
      retired_d = retired_q + CNT_W'(1);
      state_d   = start_i ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_o = retired_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: dut A uses a 3-cycle fixed memory latency, dut B the ready handshake.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    logic [3:0]  st;
    ctl_t        ctl;
    logic [31:0] ret;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_a, rdy_a, start_b, rdy_b;
  logic [5:0]  op_a, op_b;
  wire  [16:0] ca, cb;
  wire  [3:0]  st_a, st_b;
  wire  [3:0]  ret_a;
  wire  [31:0] ret_b;

  multicycle_ctrl #(.MEM_LAT(3), .USE_READY(0), .CNT_W(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .Op_i(op_a), .mem_ready_i(rdy_a),
    .PCWrite_o(ca[16]), .PCWriteCond_o(ca[15]), .IorD_o(ca[14]), .MemRead_o(ca[13]),
    .MemWrite_o(ca[12]), .IRWrite_o(ca[11]), .MemtoReg_o(ca[10]), .RegDst_o(ca[9]),
    .RegWrite_o(ca[8]), .ALUSrcA_o(ca[7]), .ALUSrcB_o(ca[6:5]), .ALUOp_o(ca[4:3]),
    .PCSource_o(ca[2:1]), .illegal_o(ca[0]), .retired_o(ret_a), .state_o(st_a)
  );

  multicycle_ctrl #(.MEM_LAT(1), .USE_READY(1), .CNT_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .Op_i(op_b), .mem_ready_i(rdy_b),
    .PCWrite_o(cb[16]), .PCWriteCond_o(cb[15]), .IorD_o(cb[14]), .MemRead_o(cb[13]),
    .MemWrite_o(cb[12]), .IRWrite_o(cb[11]), .MemtoReg_o(cb[10]), .RegDst_o(cb[9]),
    .RegWrite_o(cb[8]), .ALUSrcA_o(cb[7]), .ALUSrcB_o(cb[6:5]), .ALUOp_o(cb[4:3]),
    .PCSource_o(cb[2:1]), .illegal_o(cb[0]), .retired_o(ret_b), .state_o(st_b)
  );

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_ret [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Control word each state must present, taken directly from the state table.
  function automatic ctl_t ctl_of(input state_e s, input logic done, input logic ill);
    ctl_t c = '0;
    case (s)
      S_FETCH:   begin c.mrd = 1'b1; c.srcb = 2'd1; c.irw = done; c.pcw = done; end
      S_DECODE:  begin c.srcb = 2'd3; c.ill = ill; end
      S_MEMADR,
      S_ADDI_EX: begin c.srca = 1'b1; c.srcb = 2'd2; end
      S_MEMRD:   begin c.mrd = 1'b1; c.iord = 1'b1; end
      S_MEMWR:   begin c.mwr = 1'b1; c.iord = 1'b1; end
      S_MEMWB:   begin c.rwr = 1'b1; c.m2r = 1'b1; end
      S_RWB:     begin c.rwr = 1'b1; c.rdst = 1'b1; end
      S_ADDI_WB: c.rwr = 1'b1;
      S_EXEC:    begin c.srca = 1'b1; c.aluop = 2'd2; end
      S_BRANCH:  begin c.srca = 1'b1; c.aluop = 2'd1; c.pcwc = 1'b1; c.pcsrc = 2'd1; end
      S_JUMP:    begin c.pcw = 1'b1; c.pcsrc = 2'd2; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  task automatic cyc(input int d, input logic st, input logic [5:0] op, input logic rdy,
                     input state_e es, input logic done, input logic ill);
    exp_t        e;
    logic [16:0] oc;
    logic [3:0]  os;
    logic [31:0] orr;
    @(negedge clk);
    if (d == 0) begin start_a = st; op_a = op; rdy_a = rdy; end
    else        begin start_b = st; op_b = op; rdy_b = rdy; end
    e.st  = es;
    e.ctl = ctl_of(es, done, ill);
    e.ret = (d == 0) ? (exp_ret[0] & 32'hF) : exp_ret[1];
    sb.push_back(e);
    #2;
    os  = (d != 0) ? st_b : st_a;
    oc  = (d != 0) ? cb : ca;
    orr = (d != 0) ? ret_b : {28'd0, ret_a};
    e = sb.pop_front();
    check($sformatf("d%0d.state", d), {28'd0, os}, {28'd0, e.st});
    check($sformatf("d%0d.ctl@%0d", d, e.st), {15'd0, oc}, {15'd0, e.ctl});
    check($sformatf("d%0d.retired", d), orr, e.ret);
  endtask

  // Dut A counts its latency and must ignore ready, so ready is driven inverted against it.
  task automatic mem(input int d, input logic st, input logic [5:0] op, input state_e es, input int w);
    for (int i = 0; i < w; i++) cyc(d, st, op, (d == 0), es, 1'b0, 1'b0);
    cyc(d, st, op, (d != 0), es, 1'b1, 1'b0);
  endtask

  task automatic instr(input int d, input logic [5:0] op, input logic st, input int w);
    logic ill;
    ill = !(op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
    mem(d, st, op, S_FETCH, w);
    cyc(d, st, op, 1'b1, S_DECODE, 1'b0, ill);
    case (op)
      OP_RTYPE: begin cyc(d, st, op, 1'b1, S_EXEC, 1'b0, 1'b0); cyc(d, st, op, 1'b1, S_RWB, 1'b0, 1'b0); end
      OP_LW: begin
        cyc(d, st, op, 1'b1, S_MEMADR, 1'b0, 1'b0);
        mem(d, st, op, S_MEMRD, w);
        cyc(d, st, op, 1'b1, S_MEMWB, 1'b0, 1'b0);
      end
      OP_SW: begin cyc(d, st, op, 1'b1, S_MEMADR, 1'b0, 1'b0); mem(d, st, op, S_MEMWR, w); end
      OP_BEQ:  cyc(d, st, op, 1'b1, S_BRANCH, 1'b0, 1'b0);
      OP_J:    cyc(d, st, op, 1'b1, S_JUMP, 1'b0, 1'b0);
      OP_ADDI: begin cyc(d, st, op, 1'b1, S_ADDI_EX, 1'b0, 1'b0); cyc(d, st, op, 1'b1, S_ADDI_WB, 1'b0, 1'b0); end
      default: ;
    endcase
    if (!ill) exp_ret[d] = exp_ret[d] + 32'd1;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; rdy_a = 1'b0; op_a = OP_RTYPE;
    start_b = 1'b0; rdy_b = 1'b0; op_b = OP_RTYPE;
    exp_ret[0] = 32'd0;
    exp_ret[1] = 32'd0;
    #2;
    check("rst.a.state", {28'd0, st_a}, {28'd0, S_IDLE});
    check("rst.a.ctl", {15'd0, ca}, 32'd0);
    check("rst.a.retired", {28'd0, ret_a}, 32'd0);
    check("rst.b.state", {28'd0, st_b}, {28'd0, S_IDLE});
    check("rst.b.ctl", {15'd0, cb}, 32'd0);
    check("rst.b.retired", ret_b, 32'd0);
    rst = 1'b0;

    // Dut A: one full lw, then a lw abandoned by reset in the middle of its read wait.
    cyc(0, 1'b1, OP_LW, 1'b1, S_IDLE, 1'b0, 1'b0);
    instr(0, OP_LW, 1'b1, 2);
    mem(0, 1'b1, OP_LW, S_FETCH, 2);
    cyc(0, 1'b1, OP_LW, 1'b1, S_DECODE, 1'b0, 1'b0);
    cyc(0, 1'b1, OP_LW, 1'b1, S_MEMADR, 1'b0, 1'b0);
    cyc(0, 1'b1, OP_LW, 1'b1, S_MEMRD, 1'b0, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst.a.state", {28'd0, st_a}, {28'd0, S_IDLE});
    check("midrst.a.ctl", {15'd0, ca}, 32'd0);
    check("midrst.a.retired", {28'd0, ret_a}, 32'd0);
    exp_ret[0] = 32'd0;
    start_a = 1'b0;
    #1 rst = 1'b0;

    // 17 R-type on a 4-bit counter; start drops during the last one.
    cyc(0, 1'b1, OP_RTYPE, 1'b1, S_IDLE, 1'b0, 1'b0);
    for (int n = 0; n < 16; n++) instr(0, OP_RTYPE, 1'b1, 2);
    instr(0, OP_RTYPE, 1'b0, 2);
    cyc(0, 1'b0, OP_RTYPE, 1'b1, S_IDLE, 1'b0, 1'b0);
    cyc(0, 1'b0, OP_RTYPE, 1'b1, S_IDLE, 1'b0, 1'b0);

    // Dut B: ready-stretched fetch, beq then j, illegal opcode, then every other class.
    cyc(1, 1'b1, OP_RTYPE, 1'b1, S_IDLE, 1'b0, 1'b0);
    instr(1, OP_RTYPE, 1'b1, 4);
    instr(1, OP_BEQ, 1'b1, 0);
    instr(1, OP_J, 1'b1, 0);
    instr(1, 6'b111111, 1'b1, 0);
    instr(1, OP_ADDI, 1'b1, 1);
    instr(1, OP_SW, 1'b1, 2);
    instr(1, OP_LW, 1'b1, 0);
    instr(1, 6'b111111, 1'b0, 0);
    cyc(1, 1'b1, OP_LW, 1'b1, S_IDLE, 1'b0, 1'b0);
    instr(1, OP_LW, 1'b0, 3);
    cyc(1, 1'b0, OP_LW, 1'b1, S_IDLE, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised control unit for the multi-cycle MIPS-subset CPU. It replaces the single-cycle combinational decoder with a registered finite state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps. Shared memory accesses are stretched either by a fixed-latency counter or by a ready handshake, and the block counts retired instructions. It sits between the instruction register opcode field and the multi-cycle datapath muxes, register file, ALU control, PC and unified memory.

## Interface
- MEM_LAT, 1: memory access cycles when USE_READY=0; must be ≥1.
- USE_READY, 0: 0 = fixed-latency memory; 1 = wait on mem_ready_i.
- CNT_W, 32: retired-instruction counter width.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  run enable; sampled in IDLE and at each instruction boundary.
- Op_i  in  6  opcode from the instruction register, bits [31:26].
- mem_ready_i  in  1  memory done; used only when USE_READY=1.
- PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o  out  1 each  datapath controls.
- ALUSrcB_o  out  2  ALU B select: 0 = reg B, 1 = constant 4, 2 = sign-extended immediate, 3 = immediate shifted left 2.
- ALUOp_o  out  2  0 = add, 1 = subtract, 2 = use funct field.
- PCSource_o  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- illegal_o  out  1  one-cycle pulse on an unsupported opcode.
- retired_o  out  CNT_W  count of completed instructions.
- state_o  out  4  current state encoding, for debug.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State sequences:
  - IDLE → FETCH when start_i=1.
  - FETCH → DECODE on the memory-done cycle.
  - DECODE branches by opcode: R → EXEC → RWB; lw → MEMADR → MEMRD → MEMWB; sw → MEMADR → MEMWR; beq → BRANCH; j → JUMP; addi → ADDI_EX → ADDI_WB.
  - Illegal opcode: pulse illegal_o, go to FETCH (or IDLE if start_i=0). Do not increment retired_o.
- FETCH controls: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0. IRWrite and PCWrite assert only on the done cycle.
- DECODE controls: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target into ALUOut).
- MEMADR, ADDI_EX: ALUSrcA=1, ALUSrcB=2, ALUOp=0.
- MEMRD: MemRead=1, IorD=1, held until done.
- MEMWR: MemWrite=1, IorD=1, held until done.
- Write-back states:
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - RWB: RegWrite=1, MemtoReg=0, RegDst=1.
  - ADDI_WB: RegWrite=1, MemtoReg=0, RegDst=0.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1.
- JUMP: PCWrite=1, PCSource=2.
- Last state of each instruction (MEMWB, MEMWR-done, RWB, ADDI_WB, BRANCH, JUMP):
  - increment retired_o; it wraps modulo 2^CNT_W.
  - next state is FETCH if start_i=1, else IDLE.
- Memory done:
  - USE_READY=1: done = mem_ready_i.
  - USE_READY=0: done when the wait counter reaches MEM_LAT-1. The counter clears on entry to every memory state.
- All controls not listed for a state are 0.

## Timing
- Reset: state IDLE, all control outputs 0, illegal_o=0, retired_o=0, wait counter 0. Reset takes effect immediately, including mid-instruction or during a memory wait. A partially executed instruction is abandoned.
- Control outputs are decoded from the registered state. IRWrite, PCWrite-in-FETCH and the memory-state exits additionally depend on done; this is a combinational path from mem_ready_i.
- Cycles per instruction with MEM_LAT=1: R 4, lw 5, sw 4, beq 3, j 3, addi 4. Each memory state adds MEM_LAT-1 cycles, or the number of extra cycles mem_ready_i stays low.
- start_i deasserted mid-instruction: the instruction completes, then the FSM parks in IDLE.
- mem_ready_i high outside memory states is ignored.
- mem_ready_i high on the first cycle of a memory state gives a 1-cycle access.

## Structure
- Package multicycle_pkg contains:
  - state enum, 4 bits;
  - opcode constants;
  - ALUOp, ALUSrcB and PCSource encodings.
- The ALU_Control block imports the same ALUOp constants.
- Sub-module mem_wait_timer(MEM_LAT, USE_READY) generates done from an entry pulse and mem_ready_i.

## Test plan
- Reset during MEMRD with MEM_LAT=3 → state_o=IDLE and all outputs 0 in the same cycle; after release and start_i=1, FETCH follows on the next edge.
- MEM_LAT=1, lw (Op_i=100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB across 5 cycles; RegWrite=1 and MemtoReg=1 only in MEMWB; retired_o goes 0→1.
- USE_READY=1, mem_ready_i low for 4 cycles in FETCH → MemRead held for 5 cycles; IRWrite and PCWrite asserted exactly once, on the ready cycle.
- beq followed by j with start_i held high → 3+3 cycles, PCWriteCond=1 with PCSource=1, then PCWrite=1 with PCSource=2; retired_o=2.
- Op_i=111111 → illegal_o pulses in DECODE; next state FETCH; retired_o unchanged.
- CNT_W=4, 17 R-type instructions → retired_o=1 after wrap; start_i dropped during the 17th instruction → FSM returns to IDLE after RWB.
